fnd_scan_controller: RTL and testbench
======================================

// Module: fnd_scan_controller
// PURPOSE
//  Upstream feeder for the BCD-to-FND stage. Accepts a 14-bit binary result from the
//  calculator core, converts it to four BCD digits with a sequential shift-add-3 FSM,
//  and time-multiplexes those digits onto a 4-digit common FND. Each digit slot drives
//  digit-select, BCD value and enable straight into the font/digit decoders.
// PARAMETERS
//  SCAN_DIV   100_000  clk cycles per digit slot (1 kHz slot rate at 100 MHz); >=2
//  BIN_W      14       width of i_bin; 14 covers 0..9999
// PORTS
//  i_clk            in   1      system clock, rising edge
//  i_reset          in   1      synchronous, active-high reset
//  i_bin            in   BIN_W  binary value to display
//  i_valid          in   1      i_bin valid; accepted when i_valid && o_ready
//  o_ready          out  1      converter idle, can accept a new value
//  o_overflow       out  1      last accepted value was >9999 (displayed as 9999)
//  o_digitSelect    out  2      active digit slot, 0=ones .. 3=thousands
//  o_value          out  4      BCD digit for the active slot
//  o_en             out  1      display enable for the active slot
// BEHAVIOUR
//  Reset (i_reset=1 at a clk edge): FSM->IDLE, display regs=0000, o_ready=1,
//   o_overflow=0, prescaler=0, o_digitSelect=0, o_value=0, o_en=0.
//   Reset mid-conversion aborts it; the partial result is discarded.
//  Converter FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: o_ready=1. On i_valid: latch min(i_bin,9999) into shift reg, set
//    o_overflow=(i_bin>9999), clear 16-bit BCD accumulator, iter=0, go to SHIFT.
//   SHIFT: each cycle add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1;
//    iter++. After BIN_W shifts go to DONE. o_ready=0 throughout.
//   DONE: copy accumulator into the 4 display regs in one cycle (atomic update, no
//    torn digits), go to IDLE. Latency i_valid accept -> display update = BIN_W+1 clks.
//   i_valid while busy is ignored (no queueing); upstream holds i_valid until o_ready.
//  Scan: prescaler counts 0..SCAN_DIV-1; on terminal count it wraps to 0 and the digit
//   counter advances 0->1->2->3->0. Outputs are registered: o_digitSelect=counter,
//   o_value=display[counter]. A display update in the middle of a slot takes effect on
//   the next clk (o_value follows the display regs; the slot timing is unchanged).
//  o_en=1 for every slot from the first cycle after reset deasserts, unless blanked
//   (see CONFIGURATION).
//  The display holds the last converted value indefinitely; after reset it shows 0000.
// CONFIGURATION
//  Macro FND_LEADING_ZERO_BLANK_EN:
//   defined: o_en=0 for slot k when all digits at slots >=k are zero, for k=1..3;
//    slot 0 is never blanked (value 0 shows "0", 40 shows "40", 7 shows "7").
//   undefined: o_en=1 in every slot; all four digits shown, including leading zeros.
// TESTING
//  1. reset; check o_ready=1, o_en=0 during reset; after release, 4 slots show 0,0,0,0.
//  2. i_bin=1234 i_valid 1 clk -> o_ready=0 for 15 clks; scan shows slots 4,3,2,1;
//     o_overflow=0.
//  3. i_bin=12000 -> o_overflow=1, display 9999; then i_bin=5 -> o_overflow=0.
//  4. i_valid pulsed at 5 clks after a valid accept -> ignored; display keeps the first value.
//  5. assert i_reset at SHIFT iteration 7 -> FSM IDLE, display 0000; new value converts
//     cleanly.
//  6. SCAN_DIV=4, LEADING_ZERO_BLANK on, i_bin=40: select sequence 0,1,2,3 each
//     4 clks; o_en=1,1,0,0.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
//   Takes a binary result from the calculator core and converts it to four BCD digits
//   with a sequential shift-add-3 (double dabble) FSM. It then time-multiplexes those
//   digits onto a 4-digit common FND, one slot per SCAN_DIV clocks.
//
//   Optional feature macro: FND_LEADING_ZERO_BLANK_EN
//     defined   : slots 1..3 are disabled while they and every higher slot hold zero
//                 (slot 0 always shows).
//     undefined : all four slots are always enabled.
//
// Ports
//   i_clk          in   1      system clock, rising edge
//   i_reset        in   1      synchronous, active-high reset
//   i_bin          in   BIN_W  binary value to display
//   i_valid        in   1      i_bin valid
//   o_ready        out  1      converter idle, can accept a new value
//   o_overflow     out  1      last accepted value was >9999 (shown as 9999)
//   o_digitSelect  out  2      active digit slot, 0=ones .. 3=thousands
//   o_value        out  4      BCD digit for the active slot
//   o_en           out  1      display enable for the active slot
//   o_fsm_state    out  2      converter state (0=IDLE, 1=SHIFT, 2=DONE) for observation
//
// Handshake: a value transfers on a rising clk edge where i_valid && o_ready. A
// transfer is never queued: i_valid seen while busy is dropped. The producer keeps
// i_valid high until it sees o_ready.
module fnd_scan_controller #(
  parameter int SCAN_DIV = 100_000,
  parameter int BIN_W    = 14
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_bin,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_overflow,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_value,
  output logic             o_en,
  output logic [1:0]       o_fsm_state
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [15:0]      bcd_adj;
  logic [IW-1:0]    iter_q, iter_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      disp_q, disp_d;

  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       digit_q, digit_d;
  logic [3:0]       value_q, value_d;
  logic             en_q, en_d;

  // ---------------- converter ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      ovf_q   <= ovf_d;
      disp_q  <= disp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    ovf_d   = ovf_q;
    disp_d  = disp_q;

    // Nibbles >=5 would become >=10 after the shift, so pre-correct them by 3.
    bcd_adj = bcd_q;
    for (int n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          // Values above 9999 saturate so the display never shows a torn 5th digit.
          ovf_d   = (32'(i_bin) > 32'd9999);
          bin_d   = ovf_d ? BIN_W'(9999) : i_bin;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bcd_d  = {bcd_adj[14:0], bin_q[BIN_W-1]};
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(BIN_W - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // All four digits change on the same edge.
        disp_d  = bcd_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- scan ----------------
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc_q <= '0;
      digit_q <= '0;
      value_q <= '0;
      en_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      digit_q <= digit_d;
      value_q <= value_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    digit_d = digit_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      digit_d = digit_q + 2'd1;
    end

    // Value and enable are looked up with the next slot index so they change on
    // the same edge as o_digitSelect.
    value_d = '0;
    en_d    = 1'b1;
    unique case (digit_d)
      2'd0: value_d = disp_q[3:0];
      2'd1: value_d = disp_q[7:4];
      2'd2: value_d = disp_q[11:8];
      2'd3: value_d = disp_q[15:12];
      default: value_d = '0;
    endcase
`ifdef FND_LEADING_ZERO_BLANK_EN
    unique case (digit_d)
      2'd0: en_d = 1'b1;
      2'd1: en_d = |disp_q[15:4];
      2'd2: en_d = |disp_q[15:8];
      2'd3: en_d = |disp_q[15:12];
      default: en_d = 1'b1;
    endcase
`endif
  end

  assign o_ready       = (state_q == S_IDLE);
  assign o_overflow    = ovf_q;
  assign o_digitSelect = digit_q;
  assign o_value       = value_q;
  assign o_en          = en_q;
  assign o_fsm_state   = state_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller with a short scan period.
module tb_fnd_scan_controller;

  localparam int SCAN_DIV = 4;
  localparam int BIN_W    = 14;
`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [BIN_W-1:0] bin;
  logic             valid;
  logic             ready;
  logic             overflow;
  logic [1:0]       sel;
  logic [3:0]       value;
  logic             en;
  logic [1:0]       fsm_state;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .SCAN_DIV(SCAN_DIV),
    .BIN_W   (BIN_W)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_bin        (bin),
    .i_valid      (valid),
    .o_ready      (ready),
    .o_overflow   (overflow),
    .o_digitSelect(sel),
    .o_value      (value),
    .o_en         (en),
    .o_fsm_state  (fsm_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic accept(input logic [BIN_W-1:0] v);
    check($sformatf("ready before %0d", v), ready, 1'b1);
    bin   = v;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (ready !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(tag, ready, 1'b1);
  endtask

  // Sync to the start of slot 0, then check four full slots of SCAN_DIV clocks.
  // digits: BCD thousands..ones; en_exp bit k = expected enable of slot k.
  task automatic scan_check(input string tag, input logic [15:0] digits, input logic [3:0] en_exp);
    logic [1:0] prev;
    int k = 0;
    prev = sel;
    @(negedge clk);
    while (!(prev == 2'd3 && sel == 2'd0) && k < 20) begin
      prev = sel;
      @(negedge clk);
      k++;
    end
    check({tag, " sync"}, 16'(k < 20), 16'd1);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < SCAN_DIV; c++) begin
        check($sformatf("%s sel s%0d c%0d", tag, s, c), sel, 16'(s));
        check($sformatf("%s val s%0d c%0d", tag, s, c), value, digits[4*s +: 4]);
        check($sformatf("%s en s%0d c%0d", tag, s, c), en, en_exp[s]);
        @(negedge clk);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst   = 1'b1;
    bin   = '0;
    valid = 1'b0;

    // 1. reset
    repeat (3) @(negedge clk);
    check("rst ready", ready, 1'b1);
    check("rst en", en, 1'b0);
    check("rst sel", sel, 2'd0);
    check("rst value", value, 4'd0);
    check("rst ovf", overflow, 1'b0);
    check("rst state", fsm_state, 2'd0);
    rst = 1'b0;
    scan_check("zero", 16'h0000, BLANK ? 4'b0001 : 4'b1111);

    // 2. 1234: busy for exactly 15 clocks
    accept(14'd1234);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("busy ready c%0d", i), ready, 1'b0);
      check($sformatf("busy state c%0d", i), fsm_state, (i < 14) ? 2'd1 : 2'd2);
      @(negedge clk);
    end
    check("1234 ready after", ready, 1'b1);
    check("1234 state after", fsm_state, 2'd0);
    check("1234 ovf", overflow, 1'b0);
    scan_check("1234", 16'h1234, 4'b1111);

    // 3. overflow saturates, then clears on next in-range value
    accept(14'd12000);
    wait_ready("12000 done");
    check("12000 ovf", overflow, 1'b1);
    scan_check("12000", 16'h9999, 4'b1111);
    accept(14'd5);
    wait_ready("5 done");
    check("5 ovf", overflow, 1'b0);
    scan_check("5", 16'h0005, BLANK ? 4'b0001 : 4'b1111);

    // 4. valid pulse while busy is dropped; 40 also exercises blanking
    accept(14'd40);
    repeat (4) @(negedge clk);
    bin   = 14'd777;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("busy pulse ready", ready, 1'b0);
    wait_ready("40 done");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("40 idle c%0d", i), ready, 1'b1);
    end
    check("40 ovf", overflow, 1'b0);
    scan_check("40", 16'h0040, BLANK ? 4'b0011 : 4'b1111);

    // 5. reset at shift iteration 7 aborts and clears display
    accept(14'd9876);
    repeat (7) @(negedge clk);
    check("abort mid state", fsm_state, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort ready", ready, 1'b1);
    check("abort state", fsm_state, 2'd0);
    check("abort en", en, 1'b0);
    check("abort sel", sel, 2'd0);
    check("abort value", value, 4'd0);
    check("abort ovf", overflow, 1'b0);
    rst = 1'b0;
    scan_check("abort", 16'h0000, BLANK ? 4'b0001 : 4'b1111);
    accept(14'd321);
    wait_ready("321 done");
    scan_check("321", 16'h0321, BLANK ? 4'b0111 : 4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
